// File: rtl/alu_ex_stage_pkg.sv
// Shared definitions for the MIPS execute stage: aluc operation codes and default widths.
// The upstream ALU-control decoder imports the same package so the encodings stay in step.
package alu_ex_stage_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int TAG_W_DEF = 5;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_ADDU = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SUBU = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_NOR  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_SLL  = 5'd10;
    localparam logic [4:0] ALU_SRL  = 5'd11;
    localparam logic [4:0] ALU_SRA  = 5'd12;
    localparam logic [4:0] ALU_ROL  = 5'd13;
    localparam logic [4:0] ALU_LUI  = 5'd14;
    localparam logic [4:0] ALU_NUM  = 5'd15;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (aluc, a, b) -> (result, signed overflow, illegal code).
// Shift-type operations take the value from b and the shift amount from a[4:0].
module alu_core
    import alu_ex_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [4:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             illegal
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] rol_s;
    logic [4:0]       shamt_s;
    logic [5:0]       rsh_s;
    logic             slt_s;
    logic             sltu_s;

    assign sum_s   = a + b;
    assign diff_s  = a - b;
    assign shamt_s = a[4:0];
    // A zero shift amount gives rsh_s == WIDTH, which shifts everything out.
    assign rsh_s   = 6'(WIDTH) - {1'b0, shamt_s};
    assign rol_s   = (b << shamt_s) | (b >> rsh_s);
    assign slt_s   = ($signed(a) < $signed(b));
    assign sltu_s  = (a < b);

    // Operation select and overflow/illegal flag generation.
    always_comb begin
        result  = {WIDTH{1'b0}};
        ovf     = 1'b0;
        illegal = 1'b0;
        case (aluc)
            ALU_ADD: begin
                result = sum_s;
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_ADDU: result = sum_s;
            ALU_SUB: begin
                result = diff_s;
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUBU: result = diff_s;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_s};
            ALU_SLL:  result = b << shamt_s;
            ALU_SRL:  result = b >> shamt_s;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt_s);
            ALU_ROL:  result = rol_s;
            ALU_LUI:  result = {b[15:0], {(WIDTH-16){1'b0}}};
            default: begin
                result  = {WIDTH{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Registered execute stage: ALU result captured into a main output slot with a one-entry
// skid slot so that in_ready can be a flop while still sustaining one op per cycle.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_aluc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Slot entry layout: {result, zero, ovf, illegal, tag}.
    localparam int EW = WIDTH + 3 + TAG_W;

    logic [WIDTH-1:0] alu_result_s;
    logic             alu_ovf_s;
    logic             alu_illegal_s;
    logic [EW-1:0]    new_entry_s;
    logic             accept_s;

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [EW-1:0]    m_entry_q, m_entry_d;
    logic [EW-1:0]    s_entry_q, s_entry_d;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .aluc    (in_aluc),
        .a       (in_a),
        .b       (in_b),
        .result  (alu_result_s),
        .ovf     (alu_ovf_s),
        .illegal (alu_illegal_s)
    );

    assign new_entry_s = {alu_result_s, (alu_result_s == {WIDTH{1'b0}}), alu_ovf_s,
                          alu_illegal_s, in_tag};
    assign accept_s    = in_valid && in_ready_q;

    // Slot occupancy and data movement between input, skid slot and main slot.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_entry_d = m_entry_q;
        s_entry_d = s_entry_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || out_ready) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_entry_d = s_entry_q;
                s_valid_d = accept_s;
                if (accept_s) begin
                    s_entry_d = new_entry_s;
                end else begin
                    s_entry_d = s_entry_q;
                end
            end else begin
                m_valid_d = accept_s;
                if (accept_s) begin
                    m_entry_d = new_entry_s;
                end else begin
                    m_entry_d = m_entry_q;
                end
            end
        end else begin
            if (accept_s) begin
                s_valid_d = 1'b1;
                s_entry_d = new_entry_s;
            end else begin
                s_valid_d = s_valid_q;
            end
        end
        in_ready_d = !s_valid_d;
    end

    // State and slot registers; async reset clears everything including output data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            m_entry_q  <= {EW{1'b0}};
            s_entry_q  <= {EW{1'b0}};
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
            m_entry_q  <= m_entry_d;
            s_entry_q  <= s_entry_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign out_result  = m_entry_q[EW-1 -: WIDTH];
    assign out_zero    = m_entry_q[TAG_W+2];
    assign out_ovf     = m_entry_q[TAG_W+1];
    assign out_illegal = m_entry_q[TAG_W];
    assign out_tag     = m_entry_q[TAG_W-1:0];

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: the driver queues hand-computed expectations on
// acceptance, and a negedge monitor pops and compares on every output transfer.
module tb_alu_ex_stage;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        il;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        o;
        logic        il;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_aluc = 5'd0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_illegal;
    logic [4:0]  out_tag;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;

    alu_ex_stage #(.WIDTH(32), .TAG_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluc     (in_aluc),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_ovf     (out_ovf),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the op has been accepted.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] er, input logic eo,
                        input logic ei, output int waits);
        exp_t e;
        bit   accepted;
        in_valid = 1'b1;
        in_aluc  = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        waits    = 0;
        accepted = 1'b0;
        e.res = er;
        e.z   = (er == 32'd0);
        e.o   = eo;
        e.il  = ei;
        e.tag = tag;
        while (!accepted && waits < 50) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                accepted = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: op %0d tag %0d not accepted within 50 cycles", op, tag);
        end
        in_valid = 1'b0;
    endtask

    // Monitor: compare every completed output transfer against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            pops++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got result %h tag %0d, expected no output",
                         out_result, out_tag);
            end else begin
                e = sb_q.pop_front();
                if ({out_result, out_zero, out_ovf, out_illegal, out_tag} !== e) begin
                    errors++;
                    $display("FAIL output_tag%0d: got res=%h z=%b o=%b il=%b tag=%0d expected res=%h z=%b o=%b il=%b tag=%0d",
                             e.tag, out_result, out_zero, out_ovf, out_illegal, out_tag,
                             e.res, e.z, e.o, e.il, e.tag);
                end
            end
        end
    end

    vec_t dir_v[9];
    vec_t str_v[8];

    initial begin
        int w;
        int stall_total;
        int pops0;

        dir_v[0] = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
        dir_v[1] = '{5'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
        dir_v[2] = '{5'd2,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0};
        dir_v[3] = '{5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        dir_v[4] = '{5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        dir_v[5] = '{5'd12, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0};
        dir_v[6] = '{5'd13, 32'h00000004, 32'h80000001, 32'h00000018, 1'b0, 1'b0};
        dir_v[7] = '{5'd14, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0};
        dir_v[8] = '{5'd20, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1};

        str_v[0] = '{5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        str_v[1] = '{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        str_v[2] = '{5'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
        str_v[3] = '{5'd7,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        str_v[4] = '{5'd10, 32'h00000008, 32'h00000001, 32'h00000100, 1'b0, 1'b0};
        str_v[5] = '{5'd11, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0};
        str_v[6] = '{5'd3,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
        str_v[7] = '{5'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0};

        // Reset state
        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_flags_tag", {24'd0, out_zero, out_ovf, out_illegal, out_tag}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single ops with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(dir_v[i].op, dir_v[i].a, dir_v[i].b, 5'(i + 3), dir_v[i].r, dir_v[i].o,
                 dir_v[i].il, w);
            if (i == 0) chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("directed_drained", sb_q.size(), 32'd0);

        // Back-to-back stream of 8
        pops0 = pops;
        stall_total = 0;
        for (int i = 0; i < 8; i++) begin
            send(str_v[i].op, str_v[i].a, str_v[i].b, 5'(i + 16), str_v[i].r, str_v[i].o,
                 str_v[i].il, w);
            stall_total += w;
        end
        @(negedge clk);
        #1;
        chk("stream_in_ready_stalls", stall_total, 32'd0);
        chk("stream_consecutive_outputs", pops - pops0, 32'd8);
        @(posedge clk);
        #1;

        // Back-pressure: A into M, B into S, C held off until the output drains
        out_ready = 1'b0;
        send(5'd4, 32'h0000FFFF, 32'h00FF00FF, 5'd10, 32'h000000FF, 1'b0, 1'b0, w);
        send(5'd5, 32'h0000FFFF, 32'h00FF00FF, 5'd11, 32'h00FFFFFF, 1'b0, 1'b0, w);
        chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
        fork
            send(5'd6, 32'h0000FFFF, 32'h00FF00FF, 5'd12, 32'h00FFFF00, 1'b0, 1'b0, w);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_out_result_stable", out_result, 32'h000000FF);
                    chk("stall_out_tag_stable", {27'd0, out_tag}, 32'd10);
                    chk("stall_in_ready_held", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("stall_drained", sb_q.size(), 32'd0);

        // Flush with M and S full; the op presented in the flush cycle must vanish
        out_ready = 1'b0;
        send(5'd1, 32'h00000010, 32'h00000020, 5'd20, 32'h00000030, 1'b0, 1'b0, w);
        send(5'd1, 32'h00000040, 32'h00000020, 5'd21, 32'h00000060, 1'b0, 1'b0, w);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_aluc  = 5'd1;
        in_a     = 32'h00000001;
        in_b     = 32'h00000001;
        in_tag   = 5'd22;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        pops0 = pops;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd23;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_drop_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_nothing_emerges", pops - pops0, 32'd0);

        // Asynchronous reset while stalled with both slots full
        out_ready = 1'b0;
        send(5'd0, 32'h7FFFFFFF, 32'h00000001, 5'd7, 32'h80000000, 1'b1, 1'b0, w);
        send(5'd0, 32'h00000002, 32'h00000003, 5'd8, 32'h00000005, 1'b0, 1'b0, w);
        chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset_out_result", out_result, 32'd0);
        chk("async_reset_flags_tag", {24'd0, out_zero, out_ovf, out_illegal, out_tag}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);

        // One op after reset to confirm normal operation resumes
        send(5'd9, 32'h00000001, 32'hFFFFFFFF, 5'd30, 32'h00000001, 1'b0, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
        chk("final_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
